// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and a
// saturating-increment helper used by the optional performance counters.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_perf_ctr.sv
// Saturating access/stall counters for dmem_responder (built only when
// DMEM_PERF_CTR_EN is defined).
module dmem_perf_ctr
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_busy,
    input  logic        i_read_done,
    input  logic        i_write_done,
    output logic [31:0] o_read_count,
    output logic [31:0] o_write_count,
    output logic [31:0] o_stall_cycles
);

    logic [31:0] r_read_count;
    logic [31:0] r_write_count;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_count   <= '0;
            r_write_count  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (i_read_done) begin
                r_read_count <= sat_inc32(r_read_count);
            end
            if (i_write_done) begin
                r_write_count <= sat_inc32(r_write_count);
            end
            if (i_busy) begin
                r_stall_cycles <= sat_inc32(r_stall_cycles);
            end
        end
    end

    assign o_read_count   = r_read_count;
    assign o_write_count  = r_write_count;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: rtl/dmem_responder.sv
// Bridges single-cycle pipeline load/store requests to a handshaked backing
// memory. Optional counters are enabled with the DMEM_PERF_CTR_EN macro.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dmem_read_i,
    input  logic             dmem_write_i,
    input  logic [width-1:0] dmem_address_i,
    input  logic [width-1:0] dmem_wdata_i,
    input  logic [3:0]       dmem_byte_en_i,
    output logic [width-1:0] dmem_rdata_o,
    output logic             dmem_resp_o,
    output logic             pmem_read_o,
    output logic             pmem_write_o,
    output logic [width-1:0] pmem_address_o,
    output logic [width-1:0] pmem_wdata_o,
    output logic [3:0]       pmem_byte_en_o,
    input  logic [width-1:0] pmem_rdata_i,
    input  logic             pmem_resp_i
`ifdef DMEM_PERF_CTR_EN
    ,
    output logic [31:0]      read_count_o,
    output logic [31:0]      write_count_o,
    output logic [31:0]      stall_cycles_o
`endif
);

    localparam logic [width-1:0] ALIGN_MASK = {{(width-2){1'b1}}, 2'b00};

    dmem_state_t      r_state;
    dmem_state_t      w_next_state;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic [width-1:0] r_addr;
    logic [width-1:0] r_wdata;
    logic [3:0]       r_byte_en;
    logic             r_is_write;
    logic [width-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A store with no enabled lanes has nothing to send, so it completes
    // without ever touching the backing memory.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (dmem_read_i || dmem_write_i) begin
                    w_accept = 1'b1;
                    if (dmem_write_i && (dmem_byte_en_i == 4'b0000)) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (pmem_resp_i) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_byte_en  <= '0;
            r_is_write <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= dmem_address_i;
                r_wdata    <= dmem_wdata_i;
                r_byte_en  <= dmem_byte_en_i;
                r_is_write <= dmem_write_i;
            end
            if (w_busy && pmem_resp_i && !r_is_write) begin
                r_rdata <= pmem_rdata_i;
            end
        end
    end

    assign w_busy = (r_state == BUSY);
    assign w_done = (r_state == DONE);

    // Gating on BUSY keeps the memory side quiet in IDLE/DONE and during reset.
    assign pmem_read_o    = w_busy && !r_is_write;
    assign pmem_write_o   = w_busy && r_is_write;
    assign pmem_address_o = w_busy ? (r_addr & ALIGN_MASK) : '0;
    assign pmem_wdata_o   = w_busy ? r_wdata : '0;
    assign pmem_byte_en_o = w_busy ? r_byte_en : 4'b0000;
    assign dmem_resp_o    = w_done;
    assign dmem_rdata_o   = r_rdata;

`ifdef DMEM_PERF_CTR_EN
    dmem_perf_ctr u_perf_ctr (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_busy         (w_busy),
        .i_read_done    (w_done && !r_is_write),
        .i_write_done   (w_done && r_is_write),
        .o_read_count   (read_count_o),
        .o_write_count  (write_count_o),
        .o_stall_cycles (stall_cycles_o)
    );
`endif

endmodule
